// File: rtl/byte_packer.sv
// Receive-side byte assembler: packs the UART byte stream MSB-first into 128-bit
// blocks behind a one-deep output register, with an inter-byte idle timeout.
module byte_packer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [127:0] block_out,
  output logic         block_valid,
  input  logic         block_ready,
  output logic [4:0]   byte_count,
  output logic         overflow,
  output logic         timeout
);

  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The limit fires on the edge where the idle count would step up to TIMEOUT_CYCLES.
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  logic [127:0]      asm_r, asm_s;
  logic [3:0]        cnt_r, cnt_s;
  logic [127:0]      out_r, out_s;
  logic              out_full_r, out_full_s;
  logic              overflow_r, overflow_s;
  logic              timeout_r, timeout_s;
  logic [IDLE_W-1:0] idle_r, idle_s;
  logic [127:0]      word_s;
  logic              complete_s;

  assign word_s     = {asm_r[119:0], rx_data};
  assign complete_s = rx_valid && (cnt_r == 4'd15);

  // Next-state logic: byte accept, output-stage arbitration and idle timeout.
  always_comb begin
    asm_s      = asm_r;
    cnt_s      = cnt_r;
    out_s      = out_r;
    out_full_s = out_full_r;
    overflow_s = 1'b0;
    timeout_s  = 1'b0;
    idle_s     = idle_r;

    if (rx_valid) begin
      asm_s = word_s;
      if (cnt_r == 4'd15) begin
        cnt_s = 4'd0;
      end else begin
        cnt_s = cnt_r + 4'd1;
      end
    end else begin
      asm_s = asm_r;
    end

    // A completing block may replace a block that transfers on this same edge.
    if (complete_s) begin
      if (!out_full_r || block_ready) begin
        out_s      = word_s;
        out_full_s = 1'b1;
      end else begin
        overflow_s = 1'b1;
      end
    end else if (out_full_r && block_ready) begin
      out_full_s = 1'b0;
    end else begin
      out_full_s = out_full_r;
    end

    if ((TIMEOUT_CYCLES == 0) || rx_valid || (cnt_r == 4'd0)) begin
      idle_s = '0;
    end else if (idle_r == IDLE_LAST) begin
      idle_s    = '0;
      cnt_s     = 4'd0;
      timeout_s = 1'b1;
    end else begin
      idle_s = idle_r + IDLE_W'(1);
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      asm_r      <= 128'd0;
      cnt_r      <= 4'd0;
      out_r      <= 128'd0;
      out_full_r <= 1'b0;
      overflow_r <= 1'b0;
      timeout_r  <= 1'b0;
      idle_r     <= '0;
    end else begin
      asm_r      <= asm_s;
      cnt_r      <= cnt_s;
      out_r      <= out_s;
      out_full_r <= out_full_s;
      overflow_r <= overflow_s;
      timeout_r  <= timeout_s;
      idle_r     <= idle_s;
    end
  end

  assign block_out   = out_r;
  assign block_valid = out_full_r;
  assign byte_count  = {1'b0, cnt_r};
  assign overflow    = overflow_r;
  assign timeout     = timeout_r;

endmodule

// File: tb/tb_byte_packer.sv
// Directed self-checking bench for byte_packer: block table plus hand-written
// overflow, back-to-back, timeout, reset and full-rate sequences.
module tb_byte_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [127:0] block_out;
  logic         block_valid;
  logic         block_ready;
  logic [4:0]   byte_count;
  logic         overflow;
  logic         timeout;

  int n_vec = 0;
  int n_bad = 0;
  int ovf_pulses = 0;
  int tmo_pulses = 0;

  byte_packer #(.TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .block_out(block_out), .block_valid(block_valid), .block_ready(block_ready),
    .byte_count(byte_count), .overflow(overflow), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overflow) ovf_pulses++;
    if (timeout)  tmo_pulses++;
  end

  typedef struct {
    logic [7:0]   base;
    int           gap;
    logic [127:0] exp_block;
  } vec_t;

  vec_t vecs[3];

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    cycle();
    rx_valid = 1'b0;
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  initial begin
    logic [7:0] b;
    int valid_cycles;

    vecs[0] = '{8'h00, 10, 128'h000102030405060708090A0B0C0D0E0F};
    vecs[1] = '{8'h40, 0,  128'h404142434445464748494A4B4C4D4E4F};
    vecs[2] = '{8'hF0, 3,  128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF};

    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; block_ready = 1'b1;
    repeat (3) cycle();
    check("reset block_out",   block_out,   128'd0);
    check("reset block_valid", block_valid, 128'd0);
    check("reset byte_count",  byte_count,  128'd0);
    check("reset overflow",    overflow,    128'd0);
    check("reset timeout",     timeout,     128'd0);
    reset = 1'b1;
    cycle();

    // Table: one block per record, ready high, optional spacing between bytes.
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 16; i++) begin
        b = vecs[v].base + 8'(i);
        send_byte(b);
        if (i == 7) check("mid byte_count", byte_count, 128'd8);
        if (i < 15) repeat (vecs[v].gap) cycle();
      end
      check("table block_valid", block_valid, 128'd1);
      check("table block_out",   block_out,   vecs[v].exp_block);
      check("table byte_count",  byte_count,  128'd0);
      cycle();
      check("table valid one cycle", block_valid, 128'd0);
    end

    // Overflow: A held, B completes and is dropped.
    block_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
    check("ovf A valid", block_valid, 128'd1);
    for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i));
    check("ovf pulse",       overflow,    128'd1);
    check("ovf keeps A",     block_out,   128'h101112131415161718191A1B1C1D1E1F);
    check("ovf valid held",  block_valid, 128'd1);
    cycle();
    check("ovf one cycle",   overflow,    128'd0);
    block_ready = 1'b1;
    cycle();
    check("ovf A taken",     block_valid, 128'd0);
    cycle();
    check("ovf no B",        block_valid, 128'd0);

    // Back-to-back: A transfers while B loads on the same edge.
    block_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
    valid_cycles = 0;
    for (int i = 0; i < 15; i++) begin
      send_byte(8'h50 + 8'(i));
      if (block_valid) valid_cycles++;
    end
    check("b2b A held", 128'(valid_cycles), 128'd15);
    block_ready = 1'b1;
    send_byte(8'h5F);
    check("b2b valid no bubble", block_valid, 128'd1);
    check("b2b B loaded",        block_out,   128'h505152535455565758595A5B5C5D5E5F);
    check("b2b no overflow",     overflow,    128'd0);
    cycle();
    check("b2b B taken",         block_valid, 128'd0);

    // Timeout after 5 bytes, then a clean block.
    for (int i = 0; i < 5; i++) send_byte(8'h01 + 8'(i));
    check("tmo count 5", byte_count, 128'd5);
    repeat (49) cycle();
    check("tmo not yet",   timeout,    128'd0);
    check("tmo count kept", byte_count, 128'd5);
    cycle();
    check("tmo pulse",     timeout,    128'd1);
    check("tmo count 0",   byte_count, 128'd0);
    cycle();
    check("tmo one cycle", timeout,    128'd0);
    for (int i = 0; i < 16; i++) send_byte(8'hA0 + 8'(i));
    check("tmo next valid", block_valid, 128'd1);
    check("tmo next block", block_out,   128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    cycle();

    // Reset with a held block and a partial block.
    block_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'h60 + 8'(i));
    for (int i = 0; i < 8; i++)  send_byte(8'hC0 + 8'(i));
    reset = 1'b0;
    #1;
    check("rst block_out",   block_out,   128'd0);
    check("rst block_valid", block_valid, 128'd0);
    check("rst byte_count",  byte_count,  128'd0);
    repeat (2) cycle();
    reset = 1'b1;
    block_ready = 1'b1;
    cycle();
    for (int i = 0; i < 16; i++) send_byte(8'h70 + 8'(i));
    check("rst fresh block", block_out,   128'h707172737475767778797A7B7C7D7E7F);
    check("rst fresh valid", block_valid, 128'd1);
    cycle();

    // Full-rate: 32 consecutive strobes give two blocks 16 cycles apart.
    valid_cycles = 0;
    for (int i = 0; i < 32; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'h80 + 8'(i);
      cycle();
      if (block_valid) valid_cycles++;
      if (i == 15) check("burst block 1", block_out, 128'h808182838485868788898A8B8C8D8E8F);
      if (i == 31) check("burst block 2", block_out, 128'h909192939495969798999A9B9C9D9E9F);
      if (i == 15 || i == 31) check("burst valid", block_valid, 128'd1);
    end
    rx_valid = 1'b0;
    check("burst valid cycles", 128'(valid_cycles), 128'd2);
    cycle();
    check("burst drained", block_valid, 128'd0);

    check("total overflow pulses", 128'(ovf_pulses), 128'd1);
    check("total timeout pulses",  128'(tmo_pulses), 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/byte_packer.md
# byte_packer

Receive-side assembler that collects the byte stream from the UART receiver into 128-bit blocks for the block-cipher datapath. It mirrors the transmit-side unpacker, so the first byte received becomes the most-significant byte of the block. A double-buffered output lets collection continue while a finished block waits for downstream acceptance. An inter-byte timeout discards stale partial blocks.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 100000: idle cycles allowed between bytes of a partial block. 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in this cycle.
- block_out  out  128  assembled block; byte 0 is at [127:120], byte 15 at [7:0].
- block_valid  out  1  block_out holds an unconsumed block.
- block_ready  in  1  downstream accepts block_out.
- byte_count  out  5  bytes currently in the partial block, 0..15.
- overflow  out  1  one-cycle pulse: a completed block was dropped.
- timeout  out  1  one-cycle pulse: a partial block was discarded.

## Operation
- Storage:
  - Assembly shift register asm_reg[127:0] and counter cnt (0..15).
  - Output register out_reg[127:0] with full flag out_full. block_out = out_reg; block_valid = out_full.
- Byte accept:
  - On rx_valid, asm_reg <= {asm_reg[119:0], rx_data}.
  - If cnt < 15, cnt <= cnt + 1.
  - If cnt == 15, the block completes with word {asm_reg[119:0], rx_data}, and cnt <= 0.
- Completion, resolved against the output stage in the same cycle:
  - Output empty, or block_ready high while out_full: load out_reg, set out_full.
  - Output full and block_ready low: discard the completed word, pulse overflow. out_reg is unchanged.
- Handshake:
  - Transfer occurs when block_valid && block_ready at a rising edge.
  - If no completion happens in the same cycle, out_full <= 0.
  - out_reg holds its value after transfer; its content is don't-care while block_valid is low.
- Timeout (TIMEOUT_CYCLES > 0):
  - An idle counter resets to 0 on every rx_valid and whenever cnt == 0.
  - Otherwise it increments each cycle.
  - When it reaches TIMEOUT_CYCLES with no rx_valid that cycle: cnt <= 0, idle counter <= 0, timeout pulses for one cycle. The output stage is unaffected.
  - A byte arriving in the cycle the limit would be reached is accepted normally; no timeout occurs.
- Collection never stalls. The receiver has no backpressure; the only loss mechanisms are overflow and timeout.

## Timing
- Reset values:
  - block_out = 0, block_valid = 0, byte_count = 0, overflow = 0, timeout = 0.
  - asm_reg = 0, idle counter = 0.
- Reset asserted mid-block or with a held block clears everything immediately (asynchronous). No output is produced for the discarded data.
- byte_count reflects the updated cnt in the cycle after each rx_valid.
- Latency: block_valid is high in the cycle after the rx_valid of byte 15.
- block_out is stable while block_valid is high and block_ready is low.
- Back-to-back: the output can accept a new block in the same cycle the old one transfers, so block_valid stays high with no bubble.
- overflow and timeout are registered and high for exactly one cycle, in the cycle after the causing edge.
- Consecutive rx_valid strobes on every cycle must be supported. Sixteen-cycle block bursts complete at the full rate.

## Test plan
- Reset release, then 16 strobes of 0x00..0x0F spaced 10 cycles apart, block_ready held high:
  - block_out = 128'h000102030405060708090A0B0C0D0E0F.
  - block_valid is high for exactly 1 cycle, beginning 1 cycle after the 16th strobe.
  - byte_count returns to 0.
- block_ready held low; send block A (0x10..0x1F), then 16 bytes of block B:
  - The B completion produces an overflow pulse.
  - block_out remains A and block_valid stays high.
  - Raising block_ready then transfers A; block_valid drops; no B appears.
- block_ready low; send A, then 15 bytes of B, raise block_ready in the same cycle as B's 16th byte:
  - A transfers and out_reg loads B in the same cycle.
  - block_valid remains high continuously; no overflow pulse.
- TIMEOUT_CYCLES=50; send 5 bytes, then idle:
  - timeout pulses 50 cycles after the last byte; byte_count becomes 0.
  - The next 16 bytes 0xA0..0xAF produce block_out = 128'hA0A1...AF.
- Send 8 bytes, assert reset low for 2 cycles, then send 16 fresh bytes:
  - Outputs are 0 during reset.
  - The following block contains only the 16 fresh bytes.
- Send 32 strobes on consecutive cycles with block_ready high:
  - Two correct blocks are produced, 16 cycles apart.
  - No overflow or timeout pulse.
